// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register with a valid/ready handshake and a one-entry skid buffer.
// Supports a synchronous flush, bubble-gated control outputs and a saturating stall counter.
module ex_mem_stage_reg #(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   RegWrite,
  input  logic                   Branch,
  input  logic                   MemWrite,
  input  logic                   MemRead,
  input  logic                   MemToReg,
  input  logic                   Zero,
  input  logic [DATA_W-1:0]      ALUResult,
  input  logic [DATA_W-1:0]      WriteMemData,
  input  logic [DATA_W-1:0]      pc_plus_4,
  input  logic [REG_ADDR_W-1:0]  WriteReg,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   RegWrite_out,
  output logic                   Branch_out,
  output logic                   MemWrite_out,
  output logic                   MemRead_out,
  output logic                   MemToReg_out,
  output logic                   Zero_out,
  output logic                   PCSrc_out,
  output logic [DATA_W-1:0]      ALUResult_out,
  output logic [DATA_W-1:0]      WriteMemData_out,
  output logic [DATA_W-1:0]      pc_plus_4_out,
  output logic [REG_ADDR_W-1:0]  WriteReg_out,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef struct packed {
    logic                  reg_write;
    logic                  branch;
    logic                  mem_write;
    logic                  mem_read;
    logic                  mem_to_reg;
    logic                  zero;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     write_mem_data;
    logic [DATA_W-1:0]     pc_plus_4;
    logic [REG_ADDR_W-1:0] write_reg;
  } beat_t;

  beat_t                  in_beat;
  beat_t                  main_q, main_d;
  beat_t                  skid_q, skid_d;
  logic                   main_valid_q, main_valid_d;
  logic                   skid_valid_q, skid_valid_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   accept;
  logic                   pop;

  assign in_beat = {RegWrite, Branch, MemWrite, MemRead, MemToReg, Zero,
                    ALUResult, WriteMemData, pc_plus_4, WriteReg};

  // in_ready comes straight from the skid flop, so out_ready never reaches it combinationally.
  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready;
  assign pop      = main_valid_q && out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    stall_d      = stall_q;

    if (main_valid_q && !out_ready && (stall_q != {STALL_CNT_W{1'b1}})) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      if (accept) begin
        main_d       = in_beat;
        main_valid_d = 1'b1;
      end
    end else if (!skid_valid_q) begin
      if (pop && accept) begin
        main_d = in_beat;
      end else if (pop) begin
        main_valid_d = 1'b0;
      end else if (accept) begin
        skid_d       = in_beat;
        skid_valid_d = 1'b1;
      end
    end else if (pop) begin
      main_d       = skid_q;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      stall_q      <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      stall_q      <= stall_d;
    end
  end

  // Side-effecting controls are masked so a bubble can never write or redirect.
  assign out_valid        = main_valid_q;
  assign RegWrite_out     = main_valid_q && main_q.reg_write;
  assign Branch_out       = main_valid_q && main_q.branch;
  assign MemWrite_out     = main_valid_q && main_q.mem_write;
  assign MemRead_out      = main_valid_q && main_q.mem_read;
  assign PCSrc_out        = main_valid_q && main_q.branch && main_q.zero;
  assign MemToReg_out     = main_q.mem_to_reg;
  assign Zero_out         = main_q.zero;
  assign ALUResult_out    = main_q.alu_result;
  assign WriteMemData_out = main_q.write_mem_data;
  assign pc_plus_4_out    = main_q.pc_plus_4;
  assign WriteReg_out     = main_q.write_reg;
  assign stall_cycles     = stall_q;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Self-checking bench for ex_mem_stage_reg: directed scenarios plus a randomized run against
// a queue-based reference model. A second instance with a 3-bit stall counter checks saturation.
module tb_ex_mem_stage_reg;

  typedef struct packed {
    logic        rw, br, mw, mr, mtr, z;
    logic [31:0] alu, wmd, pc4;
    logic [4:0]  wr;
  } beat_t;

  logic clk, rst_n, flush, in_valid, out_ready;
  logic RegWrite, Branch, MemWrite, MemRead, MemToReg, Zero;
  logic [31:0] ALUResult, WriteMemData, pc_plus_4;
  logic [4:0]  WriteReg;

  logic in_ready, out_valid, RegWrite_out, Branch_out, MemWrite_out, MemRead_out;
  logic MemToReg_out, Zero_out, PCSrc_out;
  logic [31:0] ALUResult_out, WriteMemData_out, pc_plus_4_out;
  logic [4:0]  WriteReg_out;
  logic [15:0] stall_cycles;

  logic s_in_ready, s_out_valid, s_RegWrite_out, s_Branch_out, s_MemWrite_out, s_MemRead_out;
  logic s_MemToReg_out, s_Zero_out, s_PCSrc_out;
  logic [31:0] s_ALUResult_out, s_WriteMemData_out, s_pc_plus_4_out;
  logic [4:0]  s_WriteReg_out;
  logic [2:0]  s_stall;

  int errors = 0;
  int checks = 0;

  // Reference model: the held beats in acceptance order, the beat last shown at the output,
  // and an unbounded count of stalled edges.
  beat_t mq[$];
  beat_t last;
  beat_t cur;
  int    mstall;

  ex_mem_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .RegWrite(RegWrite), .Branch(Branch), .MemWrite(MemWrite), .MemRead(MemRead),
    .MemToReg(MemToReg), .Zero(Zero), .ALUResult(ALUResult), .WriteMemData(WriteMemData),
    .pc_plus_4(pc_plus_4), .WriteReg(WriteReg), .out_valid(out_valid), .out_ready(out_ready),
    .RegWrite_out(RegWrite_out), .Branch_out(Branch_out), .MemWrite_out(MemWrite_out),
    .MemRead_out(MemRead_out), .MemToReg_out(MemToReg_out), .Zero_out(Zero_out),
    .PCSrc_out(PCSrc_out), .ALUResult_out(ALUResult_out), .WriteMemData_out(WriteMemData_out),
    .pc_plus_4_out(pc_plus_4_out), .WriteReg_out(WriteReg_out), .stall_cycles(stall_cycles)
  );

  ex_mem_stage_reg #(.STALL_CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .RegWrite(RegWrite), .Branch(Branch), .MemWrite(MemWrite), .MemRead(MemRead),
    .MemToReg(MemToReg), .Zero(Zero), .ALUResult(ALUResult), .WriteMemData(WriteMemData),
    .pc_plus_4(pc_plus_4), .WriteReg(WriteReg), .out_valid(s_out_valid), .out_ready(out_ready),
    .RegWrite_out(s_RegWrite_out), .Branch_out(s_Branch_out), .MemWrite_out(s_MemWrite_out),
    .MemRead_out(s_MemRead_out), .MemToReg_out(s_MemToReg_out), .Zero_out(s_Zero_out),
    .PCSrc_out(s_PCSrc_out), .ALUResult_out(s_ALUResult_out),
    .WriteMemData_out(s_WriteMemData_out), .pc_plus_4_out(s_pc_plus_4_out),
    .WriteReg_out(s_WriteReg_out), .stall_cycles(s_stall)
  );

  logic [109:0] obs1, obs2;
  assign obs1 = {out_valid, in_ready, RegWrite_out, Branch_out, MemWrite_out, MemRead_out,
                 MemToReg_out, Zero_out, PCSrc_out, ALUResult_out, WriteMemData_out,
                 pc_plus_4_out, WriteReg_out};
  assign obs2 = {s_out_valid, s_in_ready, s_RegWrite_out, s_Branch_out, s_MemWrite_out,
                 s_MemRead_out, s_MemToReg_out, s_Zero_out, s_PCSrc_out, s_ALUResult_out,
                 s_WriteMemData_out, s_pc_plus_4_out, s_WriteReg_out};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic beat_t rand_beat();
    beat_t b;
    b.rw  = 1'($urandom);
    b.br  = 1'($urandom);
    b.mw  = 1'($urandom);
    b.mr  = 1'($urandom);
    b.mtr = 1'($urandom);
    b.z   = 1'($urandom);
    b.alu = $urandom;
    b.wmd = $urandom;
    b.pc4 = $urandom;
    b.wr  = 5'($urandom);
    return b;
  endfunction

  function automatic beat_t mk_beat(input logic [31:0] alu, input logic br, input logic z);
    beat_t b;
    b     = rand_beat();
    b.alu = alu;
    b.br  = br;
    b.z   = z;
    b.rw  = 1'b1;
    b.mw  = 1'b1;
    b.mr  = 1'b1;
    return b;
  endfunction

  // Expected output vector: controls masked by validity, payload from the last shown beat.
  function automatic logic [109:0] expv();
    logic v;
    logic r;
    v = (mq.size() > 0);
    r = (mq.size() < 2);
    return {v, r, v & last.rw, v & last.br, v & last.mw, v & last.mr, last.mtr, last.z,
            v & last.br & last.z, last.alu, last.wmd, last.pc4, last.wr};
  endfunction

  function automatic int sat(input int n, input int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  task automatic drive(input logic v, input beat_t b);
    cur          = b;
    in_valid     = v;
    RegWrite     = b.rw;
    Branch       = b.br;
    MemWrite     = b.mw;
    MemRead      = b.mr;
    MemToReg     = b.mtr;
    Zero         = b.z;
    ALUResult    = b.alu;
    WriteMemData = b.wmd;
    pc_plus_4    = b.pc4;
    WriteReg     = b.wr;
  endtask

  // Advance one edge and update the model from the inputs the DUT just sampled.
  task automatic tick();
    int  sz;
    logic acc, pp;
    @(posedge clk);
    sz  = mq.size();
    acc = in_valid && (sz < 2);
    pp  = (sz > 0) && out_ready;
    if (sz > 0 && !out_ready) mstall++;
    if (flush) begin
      mq.delete();
    end else begin
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back(cur);
    end
    if (mq.size() > 0) last = mq[0];
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0);
    mq.delete();
    last   = '0;
    mstall = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0);
    mq.delete();
    last   = '0;
    mstall = 0;
    #2;
    checks++;
    if (obs1 !== {1'b0, 1'b1, 108'h0}) begin
      errors++;
      $display("[TB] FAIL reset_outputs got=%h want=%h", obs1, {1'b0, 1'b1, 108'h0});
    end
    checks++;
    if (stall_cycles !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_stall got=%0d want=0", stall_cycles);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, mk_beat(32'(16 * (i + 1)), 1'b0, 1'b0));
      tick();
      checks++;
      if (out_valid !== 1'b1 || ALUResult_out !== 32'(16 * (i + 1)) || in_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stream_beat%0d got v=%b alu=%h rdy=%b want v=1 alu=%h rdy=1",
                 i, out_valid, ALUResult_out, in_ready, 32'(16 * (i + 1)));
      end
    end
    drive(1'b0, '0);
    tick();
    checks++;
    if (out_valid !== 1'b0 || stall_cycles !== 16'h0 || obs1 !== expv()) begin
      errors++;
      $display("[TB] FAIL stream_drain got v=%b stall=%0d want v=0 stall=0",
               out_valid, stall_cycles);
    end
  endtask

  task automatic test_stall_fill();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, mk_beat(32'h11, 1'b0, 1'b0));
    tick();
    drive(1'b1, mk_beat(32'h22, 1'b0, 1'b0));
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || ALUResult_out !== 32'h11) begin
      errors++;
      $display("[TB] FAIL fill_occ2 got rdy=%b v=%b alu=%h want rdy=0 v=1 alu=11",
               in_ready, out_valid, ALUResult_out);
    end
    drive(1'b1, mk_beat(32'h33, 1'b0, 1'b0));
    tick();
    checks++;
    if (in_ready !== 1'b0 || ALUResult_out !== 32'h11 || obs1 !== expv()) begin
      errors++;
      $display("[TB] FAIL fill_hold got rdy=%b alu=%h want rdy=0 alu=11", in_ready, ALUResult_out);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (ALUResult_out !== 32'h22 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fill_pop_a got alu=%h v=%b rdy=%b want alu=22 v=1 rdy=1",
               ALUResult_out, out_valid, in_ready);
    end
    tick();
    checks++;
    if (ALUResult_out !== 32'h33 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fill_pop_b got alu=%h v=%b want alu=33 v=1", ALUResult_out, out_valid);
    end
    drive(1'b0, '0);
    tick();
    checks++;
    if (out_valid !== 1'b0 || stall_cycles !== 16'd2) begin
      errors++;
      $display("[TB] FAIL fill_stall got v=%b stall=%0d want v=0 stall=2", out_valid, stall_cycles);
    end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, mk_beat(32'hA1, 1'b1, 1'b1));
    tick();
    drive(1'b1, mk_beat(32'hA2, 1'b1, 1'b1));
    tick();
    drive(1'b1, mk_beat(32'h99, 1'b1, 1'b1));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0);
    checks++;
    if ({out_valid, in_ready, RegWrite_out, MemWrite_out, MemRead_out, PCSrc_out, Branch_out}
        !== 7'b0100000) begin
      errors++;
      $display("[TB] FAIL flush_gate got v=%b rdy=%b rw=%b mw=%b mr=%b pcs=%b br=%b want 0100000",
               out_valid, in_ready, RegWrite_out, MemWrite_out, MemRead_out, PCSrc_out, Branch_out);
    end
    checks++;
    if (ALUResult_out !== 32'hA1 || stall_cycles !== 16'd2) begin
      errors++;
      $display("[TB] FAIL flush_keep got alu=%h stall=%0d want alu=a1 stall=2",
               ALUResult_out, stall_cycles);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || ALUResult_out === 32'h99) begin
        errors++;
        $display("[TB] FAIL flush_after%0d got v=%b alu=%h want v=0 alu!=99",
                 i, out_valid, ALUResult_out);
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, mk_beat(32'hB1, 1'b1, 1'b1));
    tick();
    drive(1'b1, mk_beat(32'hB2, 1'b1, 1'b0));
    checks++;
    if (PCSrc_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL branch_taken got pcsrc=%b want 1", PCSrc_out);
    end
    tick();
    drive(1'b0, '0);
    checks++;
    if (PCSrc_out !== 1'b0 || Branch_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL branch_not_taken got pcsrc=%b br=%b want pcsrc=0 br=1",
               PCSrc_out, Branch_out);
    end
    tick();
    checks++;
    if (PCSrc_out !== 1'b0 || Branch_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL branch_bubble got pcsrc=%b br=%b want 0 0", PCSrc_out, Branch_out);
    end
    out_ready = 1'b0;
    drive(1'b1, mk_beat(32'hB3, 1'b1, 1'b1));
    tick();
    drive(1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (PCSrc_out !== 1'b1) begin
        errors++;
        $display("[TB] FAIL branch_stalled%0d got pcsrc=%b want 1", i, PCSrc_out);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (PCSrc_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL branch_consumed got pcsrc=%b want 0", PCSrc_out);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, mk_beat(32'hC0, 1'b0, 1'b0));
    tick();
    drive(1'b1, mk_beat(32'hC8, 1'b0, 1'b0));
    tick();
    drive(1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cycles !== 16'h0) begin
      errors++;
      $display("[TB] FAIL async_reset got v=%b rdy=%b stall=%0d want v=0 rdy=1 stall=0",
               out_valid, in_ready, stall_cycles);
    end
    mq.delete();
    last   = '0;
    mstall = 0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, mk_beat(32'hC1, 1'b0, 1'b0));
    tick();
    drive(1'b0, '0);
    checks++;
    if (out_valid !== 1'b1 || ALUResult_out !== 32'hC1) begin
      errors++;
      $display("[TB] FAIL async_release got v=%b alu=%h want v=1 alu=c1", out_valid, ALUResult_out);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, mk_beat(32'hD1, 1'b0, 1'b0));
    tick();
    drive(1'b0, '0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (s_stall !== 3'(sat(i, 7)) || stall_cycles !== 16'(i)) begin
        errors++;
        $display("[TB] FAIL sat_cycle%0d got s3=%0d s16=%0d want s3=%0d s16=%0d",
                 i, s_stall, stall_cycles, sat(i, 7), i);
      end
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      drive(($urandom_range(0, 3) != 0), rand_beat());
      tick();
      checks++;
      if (obs1 !== expv()) begin
        errors++;
        $display("[TB] FAIL rand_out%0d got=%h want=%h", i, obs1, expv());
      end
      checks++;
      if (obs2 !== expv()) begin
        errors++;
        $display("[TB] FAIL rand_sat_out%0d got=%h want=%h", i, obs2, expv());
      end
      checks++;
      if (stall_cycles !== 16'(sat(mstall, 65535)) || s_stall !== 3'(sat(mstall, 7))) begin
        errors++;
        $display("[TB] FAIL rand_stall%0d got s16=%0d s3=%0d want s16=%0d s3=%0d",
                 i, stall_cycles, s_stall, sat(mstall, 65535), sat(mstall, 7));
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_fill();
    test_flush();
    test_branch();
    test_async_reset();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage_reg.md
Name: ex_mem_stage_reg

Overview:
- Parametrised EX/MEM pipeline stage register with a valid/ready handshake, a one-entry skid buffer, a synchronous flush and bubble-safe control gating.
- Sits between the execute stage (ALU, branch compare) and the memory stage.
- Lets the memory stage stall without losing an in-flight instruction.
- Lets branch/exception logic squash both held instructions in one cycle.

Parameters:
- DATA_W, 32, width of ALUResult, WriteMemData and pc_plus_4.
- REG_ADDR_W, 5, width of the destination register index.
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  EX presents a beat.
- in_ready  out  1  stage can accept a beat; equals !skid_valid.
- RegWrite, Branch, MemWrite, MemRead, MemToReg, Zero  in  1 each  EX control/status.
- ALUResult, WriteMemData, pc_plus_4  in  DATA_W each  EX data.
- WriteReg  in  REG_ADDR_W  destination register.
- out_valid  out  1  main entry holds a valid beat.
- out_ready  in  1  MEM accepts the beat this cycle.
- RegWrite_out, Branch_out, MemWrite_out, MemRead_out, MemToReg_out, Zero_out  out  1 each  registered control.
- PCSrc_out  out  1  out_valid & Branch_out & Zero_out.
- ALUResult_out, WriteMemData_out, pc_plus_4_out  out  DATA_W each  registered data.
- WriteReg_out  out  REG_ADDR_W  registered destination.
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with out_valid & !out_ready.

Behaviour:
- Reset (rst_n low, asynchronous):
  - main_valid=0, skid_valid=0, all payload registers=0, stall_cycles=0.
  - in_ready=1 and all outputs read 0 while in reset.
- Storage:
  - Main entry drives the outputs.
  - Skid entry holds one overflow beat.
  - Occupancy is 0, 1 (main only) or 2 (main+skid). Skid is never valid while main is empty.
- Definitions: accept = in_valid & in_ready; pop = out_valid & out_ready.
- Transitions per edge when flush=0:
  - occ0: accept -> main<=in, occ1.
  - occ1:
    - pop & accept -> main<=in, stay occ1.
    - pop & !accept -> occ0.
    - !pop & accept -> skid<=in, occ2.
    - !pop & !accept -> hold.
  - occ2 (in_ready=0):
    - pop -> main<=skid, occ1.
    - else hold.
- Latency and throughput:
  - Latency is 1 cycle from accept to out_valid when not stalled.
  - Throughput is 1 beat/cycle.
  - in_ready is registered, so it has no combinational path from out_ready.
- Flush:
  - On an edge with flush=1: main_valid<=0, skid_valid<=0, any same-cycle input beat is discarded, occ0 next cycle.
  - Flush overrides accept and pop.
  - A pop in the same cycle still counts as consumed by MEM.
- Bubble gating (combinational from valid):
  - RegWrite_out, MemWrite_out, MemRead_out, Branch_out and PCSrc_out are forced 0 when out_valid=0.
  - Data outputs, MemToReg_out, Zero_out and WriteReg_out keep their last registered value while invalid.
- Payload integrity: beats leave in acceptance order, with none lost or duplicated, across any stall pattern.
- stall_cycles:
  - Increments by 1 on each edge where out_valid & !out_ready.
  - Saturates at 2^STALL_CNT_W-1.
  - Cleared only by reset; flush does not clear it.
- Reset mid-operation: all in-flight beats are dropped immediately (asynchronous). The first edge after rst_n rises behaves as occ0.

Test Plan:
- Reset then stream: out_ready=1, 4 beats with ALUResult 0x10,0x20,0x30,0x40 -> out_valid 1 cycle later each; outputs 0x10..0x40 on consecutive cycles; in_ready stays 1; stall_cycles=0.
- Stall fill: out_ready=0, send beats A=0x11, B=0x22 -> after 2 edges occ2, in_ready=0, output holds A. A third beat C offered while in_ready=0 must not be captured. Raise out_ready -> A, B in order, then C accepted; stall_cycles equals the stalled-cycle count.
- Flush during occ2 with in_valid=1 carrying 0x99 -> next cycle out_valid=0, in_ready=1, RegWrite_out=MemWrite_out=MemRead_out=PCSrc_out=0; 0x99 never appears at the output.
- Branch: Branch=1, Zero=1 beat -> PCSrc_out=1 for exactly the cycle(s) that beat is valid at the output. Branch=1, Zero=0 -> PCSrc_out=0.
- Async reset asserted mid-cycle while occ2 -> out_valid and in_ready outputs change without a clock edge (out_valid=0, in_ready=1). The next beat after release emerges with 1-cycle latency.
- Saturation with STALL_CNT_W=3: hold out_valid=1, out_ready=0 for 10 cycles -> stall_cycles reaches 7 and stays at 7.
